// File: rtl/fpu_operand_prep_pipe_pkg.sv
// Shared definitions for the pipelined FPU operand preprocessor: class bit
// indices, per-operand flag record and width helpers for any IEEE format.
package fpu_defs_prep;

    typedef enum logic [3:0] {
        CLS_NEG_INF  = 4'd0,
        CLS_NEG_NORM = 4'd1,
        CLS_NEG_SUB  = 4'd2,
        CLS_NEG_ZERO = 4'd3,
        CLS_POS_ZERO = 4'd4,
        CLS_POS_SUB  = 4'd5,
        CLS_POS_NORM = 4'd6,
        CLS_POS_INF  = 4'd7,
        CLS_SNAN     = 4'd8,
        CLS_QNAN     = 4'd9
    } class_idx_e;

    localparam int unsigned C_CLASS_W = 10;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
        logic snan;
        logic den;
        logic flushed;
    } op_flags_t;

    function automatic int unsigned op_width(input int unsigned exp_w, input int unsigned mant_w);
        return 1 + exp_w + mant_w;
    endfunction

    // Two extra bits: one for the all-ones exponent, one for the sign of 1-lz.
    function automatic int unsigned exps_width(input int unsigned exp_w);
        return exp_w + 2;
    endfunction

    function automatic int unsigned lzc_width(input int unsigned mant_w);
        return $clog2(mant_w + 2);
    endfunction

    // Binary32 view of the derived widths and the prepared-operand record.
    localparam int unsigned C_OP_W   = op_width(8, 23);
    localparam int unsigned C_EXPS_W = exps_width(8);
    localparam int unsigned C_LZC_W  = lzc_width(23);
    localparam logic [7:0]  C_EXP_INF   = '1;
    localparam logic [22:0] C_MANT_ZERO = '0;

    typedef struct packed {
        logic                 sign;
        logic [C_EXPS_W-1:0]  exp;
        logic [23:0]          mant;
        logic [C_CLASS_W-1:0] cls;
        op_flags_t            flags;
    } op_prep_t;

endpackage

// File: rtl/fpu_operand_prep_pipe_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
    parameter int unsigned WIDTH = 24,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] lz_count
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        lz_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) lz_count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_operand_prep_pipe.sv
// Two-stage elastic operand preprocessor: stage 1 classifies raw operands,
// stage 2 pre-normalises denormals (or flushes them) for the FMAC datapaths.
module fpu_operand_prep_pipe
    import fpu_defs_prep::*;
#(
    parameter int unsigned C_EXP_W  = 8,
    parameter int unsigned C_MANT_W = 23,
    parameter int unsigned NUM_OPS  = 3,
    parameter int unsigned TAG_W    = 4
) (
    input  logic                                      Clk_CI,
    input  logic                                      Rst_RI,
    input  logic                                      Flush_SI,
    input  logic                                      In_Valid_SI,
    output logic                                      In_Ready_SO,
    input  logic [NUM_OPS-1:0][C_EXP_W+C_MANT_W:0]    Operands_DI,
    input  logic                                      Ftz_SI,
    input  logic [TAG_W-1:0]                          Tag_DI,
    output logic                                      Out_Valid_SO,
    input  logic                                      Out_Ready_SI,
    output logic [NUM_OPS-1:0]                        Sign_DO,
    output logic [NUM_OPS-1:0][C_EXP_W+1:0]           Exp_DO,
    output logic [NUM_OPS-1:0][C_MANT_W:0]            Mant_DO,
    output logic [NUM_OPS-1:0][C_CLASS_W-1:0]         Class_DO,
    output logic [NUM_OPS-1:0]                        Zero_SO,
    output logic [NUM_OPS-1:0]                        Inf_SO,
    output logic [NUM_OPS-1:0]                        NaN_SO,
    output logic [NUM_OPS-1:0]                        SNaN_SO,
    output logic [NUM_OPS-1:0]                        DeN_SO,
    output logic [NUM_OPS-1:0]                        Flushed_SO,
    output logic [TAG_W-1:0]                          Tag_DO
);

    localparam int unsigned OP_W   = op_width(C_EXP_W, C_MANT_W);
    localparam int unsigned EXPS_W = exps_width(C_EXP_W);
    localparam int unsigned LZC_W  = lzc_width(C_MANT_W);

    logic                                s1_valid, s2_valid;
    logic                                s1_ready, s2_ready, in_fire, s1_fire;
    logic [NUM_OPS-1:0][OP_W-1:0]        s1_ops;
    op_flags_t [NUM_OPS-1:0]             s1_flags, s2_flags, cl_flags, nx_flags;
    logic [NUM_OPS-1:0][C_CLASS_W-1:0]   s1_class, s2_class, cl_class;
    logic                                s1_ftz;
    logic [TAG_W-1:0]                    s1_tag, s2_tag;
    logic [NUM_OPS-1:0]                  s2_sign, nx_sign;
    logic [NUM_OPS-1:0][EXPS_W-1:0]      s2_exp, nx_exp;
    logic [NUM_OPS-1:0][C_MANT_W:0]      s2_mant, nx_mant;

    assign s2_ready    = !s2_valid || Out_Ready_SI;
    assign s1_ready    = !s1_valid || s2_ready;
    assign In_Ready_SO = s1_ready && !Flush_SI;
    assign in_fire     = In_Valid_SI && In_Ready_SO;
    assign s1_fire     = s1_valid && s2_ready && !Flush_SI;

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        logic                 sgn, hb, exp_max, frac_nz;
        logic [C_EXP_W-1:0]   expf, exp2;
        logic [C_MANT_W-1:0]  frac, frac2;
        logic [C_CLASS_W-1:0] cls;
        op_flags_t            flg, n_flags;
        logic [LZC_W-1:0]     lz;
        logic [EXPS_W-1:0]    n_exp;
        logic [C_MANT_W:0]    n_mant;

        assign sgn     = Operands_DI[g][OP_W-1];
        assign expf    = Operands_DI[g][OP_W-2 -: C_EXP_W];
        assign frac    = Operands_DI[g][C_MANT_W-1:0];
        assign hb      = |expf;
        assign exp_max = &expf;
        assign frac_nz = |frac;

        assign flg.zero    = !hb && !frac_nz;
        assign flg.den     = !hb && frac_nz;
        assign flg.inf     = exp_max && !frac_nz;
        assign flg.nan     = exp_max && frac_nz;
        assign flg.snan    = exp_max && frac_nz && !frac[C_MANT_W-1];
        assign flg.flushed = 1'b0;

        // Class follows the raw encoding; flush-to-zero is applied later.
        always_comb begin
            cls = '0;
            if (flg.nan) begin
                if (flg.snan) cls[CLS_SNAN] = 1'b1;
                else          cls[CLS_QNAN] = 1'b1;
            end else if (flg.inf) begin
                if (sgn) cls[CLS_NEG_INF] = 1'b1;
                else     cls[CLS_POS_INF] = 1'b1;
            end else if (flg.zero) begin
                if (sgn) cls[CLS_NEG_ZERO] = 1'b1;
                else     cls[CLS_POS_ZERO] = 1'b1;
            end else if (flg.den) begin
                if (sgn) cls[CLS_NEG_SUB] = 1'b1;
                else     cls[CLS_POS_SUB] = 1'b1;
            end else begin
                if (sgn) cls[CLS_NEG_NORM] = 1'b1;
                else     cls[CLS_POS_NORM] = 1'b1;
            end
        end

        assign cl_flags[g] = flg;
        assign cl_class[g] = cls;

        assign exp2  = s1_ops[g][OP_W-2 -: C_EXP_W];
        assign frac2 = s1_ops[g][C_MANT_W-1:0];

        fpu_lzc #(.WIDTH(C_MANT_W + 1)) u_lzc (
            .data     ({1'b0, frac2}),
            .lz_count (lz)
        );

        // Denormals shift the leading one into the hidden-bit slot.
        always_comb begin
            n_exp   = {2'b00, exp2};
            n_mant  = {1'b1, frac2};
            n_flags = s1_flags[g];
            if (s1_flags[g].zero) begin
                n_exp  = '0;
                n_mant = '0;
            end else if (s1_flags[g].den) begin
                if (s1_ftz) begin
                    n_exp           = '0;
                    n_mant          = '0;
                    n_flags.zero    = 1'b1;
                    n_flags.den     = 1'b0;
                    n_flags.flushed = 1'b1;
                end else begin
                    n_mant = {1'b0, frac2} << lz;
                    n_exp  = EXPS_W'(1) - EXPS_W'(lz);
                end
            end
        end

        assign nx_sign[g]  = s1_ops[g][OP_W-1];
        assign nx_exp[g]   = n_exp;
        assign nx_mant[g]  = n_mant;
        assign nx_flags[g] = n_flags;

        assign Zero_SO[g]    = s2_flags[g].zero;
        assign Inf_SO[g]     = s2_flags[g].inf;
        assign NaN_SO[g]     = s2_flags[g].nan;
        assign SNaN_SO[g]    = s2_flags[g].snan;
        assign DeN_SO[g]     = s2_flags[g].den;
        assign Flushed_SO[g] = s2_flags[g].flushed;
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            s1_valid <= 1'b0;
            s1_ops   <= '0;
            s1_flags <= '0;
            s1_class <= '0;
            s1_ftz   <= 1'b0;
            s1_tag   <= '0;
        end else begin
            if (Flush_SI)      s1_valid <= 1'b0;
            else if (s1_ready) s1_valid <= In_Valid_SI;
            if (in_fire) begin
                s1_ops   <= Operands_DI;
                s1_flags <= cl_flags;
                s1_class <= cl_class;
                s1_ftz   <= Ftz_SI;
                s1_tag   <= Tag_DI;
            end
        end
    end

    // Stage 2 data only moves when the consumer can take it, so a stall holds outputs.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            s2_valid <= 1'b0;
            s2_sign  <= '0;
            s2_exp   <= '0;
            s2_mant  <= '0;
            s2_class <= '0;
            s2_flags <= '0;
            s2_tag   <= '0;
        end else begin
            if (Flush_SI)      s2_valid <= 1'b0;
            else if (s2_ready) s2_valid <= s1_valid;
            if (s1_fire) begin
                s2_sign  <= nx_sign;
                s2_exp   <= nx_exp;
                s2_mant  <= nx_mant;
                s2_class <= s1_class;
                s2_flags <= nx_flags;
                s2_tag   <= s1_tag;
            end
        end
    end

    assign Out_Valid_SO = s2_valid;
    assign Sign_DO      = s2_sign;
    assign Exp_DO       = s2_exp;
    assign Mant_DO      = s2_mant;
    assign Class_DO     = s2_class;
    assign Tag_DO       = s2_tag;

endmodule

// File: tb/tb_fpu_operand_prep_pipe.sv
// Directed bench for fpu_operand_prep_pipe: a binary32 instance and a
// half-precision instance share the handshake controls.
module tb_fpu_operand_prep_pipe;

    logic clk = 1'b0;
    logic rst, flush, in_valid, ftz, out_ready;
    logic [3:0] tag;

    logic                   in_ready, out_valid;
    logic [2:0][31:0]       ops;
    logic [2:0]             sign_do, zero_do, inf_do, nan_do, snan_do, den_do, flushed_do;
    logic [2:0][9:0]        exp_do;
    logic [2:0][23:0]       mant_do;
    logic [2:0][9:0]        class_do;
    logic [3:0]             tag_do;

    logic                   h_in_ready, h_out_valid;
    logic [1:0][15:0]       h_ops;
    logic [1:0]             h_sign, h_zero, h_inf, h_nan, h_snan, h_den, h_flushed;
    logic [1:0][6:0]        h_exp;
    logic [1:0][10:0]       h_mant;
    logic [1:0][9:0]        h_class;
    logic [3:0]             h_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpu_operand_prep_pipe #(.C_EXP_W(8), .C_MANT_W(23), .NUM_OPS(3), .TAG_W(4)) dut (
        .Clk_CI(clk), .Rst_RI(rst), .Flush_SI(flush), .In_Valid_SI(in_valid),
        .In_Ready_SO(in_ready), .Operands_DI(ops), .Ftz_SI(ftz), .Tag_DI(tag),
        .Out_Valid_SO(out_valid), .Out_Ready_SI(out_ready), .Sign_DO(sign_do),
        .Exp_DO(exp_do), .Mant_DO(mant_do), .Class_DO(class_do), .Zero_SO(zero_do),
        .Inf_SO(inf_do), .NaN_SO(nan_do), .SNaN_SO(snan_do), .DeN_SO(den_do),
        .Flushed_SO(flushed_do), .Tag_DO(tag_do)
    );

    fpu_operand_prep_pipe #(.C_EXP_W(5), .C_MANT_W(10), .NUM_OPS(2), .TAG_W(4)) dut_half (
        .Clk_CI(clk), .Rst_RI(rst), .Flush_SI(flush), .In_Valid_SI(in_valid),
        .In_Ready_SO(h_in_ready), .Operands_DI(h_ops), .Ftz_SI(ftz), .Tag_DI(tag),
        .Out_Valid_SO(h_out_valid), .Out_Ready_SI(out_ready), .Sign_DO(h_sign),
        .Exp_DO(h_exp), .Mant_DO(h_mant), .Class_DO(h_class), .Zero_SO(h_zero),
        .Inf_SO(h_inf), .NaN_SO(h_nan), .SNaN_SO(h_snan), .DeN_SO(h_den),
        .Flushed_SO(h_flushed), .Tag_DO(h_tag)
    );

    typedef struct {
        logic [31:0] op;
        logic        ftz;
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] mant;
        int          cls;
        logic [5:0]  flags;   // {zero, inf, nan, snan, den, flushed}
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [31:0] op, input logic f, input logic s,
                                input int e, input logic [23:0] m, input int c,
                                input logic [5:0] fl);
        vec_t v;
        v.op = op; v.ftz = f; v.sign = s; v.exp = 10'(e);
        v.mant = m; v.cls = c; v.flags = fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // One transaction with Out_Ready high; returns at the negedge of the result cycle.
    task automatic apply_stimulus(input logic [3:0] t, input logic f);
        @(posedge clk); #1;
        tag = t; ftz = f; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; ftz = ~f; ops = '1; h_ops = '1;
        @(negedge clk);
        check("latency_gap", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("latency_valid", 32'(out_valid), 32'd1);
        check("half_valid", 32'(h_out_valid), 32'd1);
    endtask

    task automatic check_output(input int i, input int k);
        string s;
        s = $sformatf("vec%0d", i);
        check({s, "_tag"},   32'(tag_do), 32'(i));
        check({s, "_sign"},  32'(sign_do[k]), 32'(vecs[i].sign));
        check({s, "_exp"},   32'(exp_do[k]), 32'(vecs[i].exp));
        check({s, "_mant"},  32'(mant_do[k]), 32'(vecs[i].mant));
        check({s, "_class"}, 32'(class_do[k]), 32'(10'd1 << vecs[i].cls));
        check({s, "_flags"}, 32'({zero_do[k], inf_do[k], nan_do[k], snan_do[k], den_do[k], flushed_do[k]}),
              32'(vecs[i].flags));
        check({s, "_other_exp"}, 32'(exp_do[(k + 1) % 3]), 32'd127);
    endtask

    task automatic run_backpressure();
        int sent = 1;
        int rcvd[$];
        logic prev_stall = 1'b0;
        logic [3:0] prev_tag = '0;
        logic [9:0] prev_exp = '0;
        for (int c = 0; c < 30 && rcvd.size() < 6; c++) begin
            @(posedge clk); #1;
            in_valid  = (sent <= 6);
            tag       = 4'(sent);
            ftz       = 1'b0;
            ops       = {3{32'h3F80_0000}};
            ops[0]    = 32'h3F80_0000 + (32'(sent) << 23);
            out_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            if (c < 8)
                check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), (c >= 3 && c <= 5) ? 32'd0 : 32'd1);
            if (prev_stall) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_tag", 32'(tag_do), 32'(prev_tag));
                check("bp_hold_exp", 32'(exp_do[0]), 32'(prev_exp));
            end
            if (out_valid && out_ready) begin
                rcvd.push_back(int'(tag_do));
                check("bp_data_exp", 32'(exp_do[0]), 32'd127 + 32'(tag_do));
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            prev_tag   = tag_do;
            prev_exp   = exp_do[0];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_count", 32'(rcvd.size()), 32'd6);
        foreach (rcvd[i]) check($sformatf("bp_order%0d", i), 32'(rcvd[i]), 32'(i + 1));
    endtask

    task automatic run_flush();
        ops = {3{32'h3F80_0000}};
        @(posedge clk); #1;
        in_valid = 1'b1; tag = 4'd10; out_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        tag = 4'd11;
        @(negedge clk);
        @(posedge clk); #1;
        tag = 4'd12; flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_pre_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; tag = 4'd13; out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_gap", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_next_valid", 32'(out_valid), 32'd1);
        check("flush_next_tag", 32'(tag_do), 32'd13);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_no_dup", 32'(out_valid), 32'd0);
    endtask

    task automatic run_reset_midstall();
        ops   = {3{32'h3F80_0000}};
        h_ops = {2{16'h3C00}};
        @(posedge clk); #1;
        in_valid = 1'b1; tag = 4'd5; out_ready = 1'b0;
        @(posedge clk); #1;
        tag = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_full", 32'(in_ready), 32'd0);
        check("stall_half_valid", 32'(h_out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_tag", 32'(tag_do), 32'd0);
        check("rst_exp", 32'(|exp_do), 32'd0);
        check("rst_mant", 32'(|mant_do), 32'd0);
        check("rst_class", 32'(|class_do), 32'd0);
        check("rst_flags", 32'(|{sign_do, zero_do, inf_do, nan_do, snan_do, den_do, flushed_do}), 32'd0);
        check("rst_half_valid", 32'(h_out_valid), 32'd0);
        check("rst_half_data", 32'(|{h_exp, h_mant, h_class, h_tag}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(out_valid || h_out_valid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; ftz = 1'b0; out_ready = 1'b0;
        tag = '0; ops = '0; h_ops = '0;

        vecs[0]  = mk(32'h0000_0001, 0, 0, -22, 24'h80_0000, 5, 6'b000010);
        vecs[1]  = mk(32'h0040_0000, 0, 0,   0, 24'h80_0000, 5, 6'b000010);
        vecs[2]  = mk(32'h8000_0001, 1, 1,   0, 24'h00_0000, 2, 6'b100001);
        vecs[3]  = mk(32'h7FC0_0000, 0, 0, 255, 24'hC0_0000, 9, 6'b001000);
        vecs[4]  = mk(32'h7F80_0001, 0, 0, 255, 24'h80_0001, 8, 6'b001100);
        vecs[5]  = mk(32'hFF80_0000, 0, 1, 255, 24'h80_0000, 0, 6'b010000);
        vecs[6]  = mk(32'h3F80_0000, 0, 0, 127, 24'h80_0000, 6, 6'b000000);
        vecs[7]  = mk(32'h0000_0000, 0, 0,   0, 24'h00_0000, 4, 6'b100000);
        vecs[8]  = mk(32'h8000_0000, 1, 1,   0, 24'h00_0000, 3, 6'b100000);
        vecs[9]  = mk(32'h007F_FFFF, 0, 0,   0, 24'hFF_FFFE, 5, 6'b000010);
        vecs[10] = mk(32'hBF80_0000, 1, 1, 127, 24'h80_0000, 1, 6'b000000);
        vecs[11] = mk(32'h0000_0001, 1, 0,   0, 24'h00_0000, 5, 6'b100001);
        vecs[12] = mk(32'h7F7F_FFFF, 0, 0, 254, 24'hFF_FFFF, 6, 6'b000000);

        #3;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(|{exp_do, mant_do, class_do, tag_do}), 32'd0);
        check("reset_flags", 32'(|{sign_do, zero_do, inf_do, nan_do, snan_do, den_do, flushed_do}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_idle", 32'(out_valid), 32'd0);

        for (int i = 0; i < 13; i++) begin
            int k;
            k = i % 3;
            ops = {3{32'h3F80_0000}};
            ops[k] = vecs[i].op;
            h_ops = {2{16'h3C00}};
            apply_stimulus(4'(i), vecs[i].ftz);
            check_output(i, k);
        end

        $display("[TB] backpressure sequence");
        run_backpressure();
        $display("[TB] flush sequence");
        run_flush();
        $display("[TB] reset mid-stall sequence");
        run_reset_midstall();

        ops = {3{32'h3F80_0000}};
        h_ops = {16'h3C00, 16'h0001};
        apply_stimulus(4'd3, 1'b0);
        check("half_tag", 32'(h_tag), 32'd3);
        check("half_den_exp", 32'(h_exp[0]), 32'(7'h77));
        check("half_den_mant", 32'(h_mant[0]), 32'h400);
        check("half_den_class", 32'(h_class[0]), 32'(10'd1 << 5));
        check("half_den_flag", 32'({h_zero[0], h_den[0], h_flushed[0]}), 32'b010);
        check("half_one_exp", 32'(h_exp[1]), 32'd15);
        check("half_one_mant", 32'(h_mant[1]), 32'h400);
        check("half_one_class", 32'(h_class[1]), 32'(10'd1 << 6));

        h_ops = {16'h7D00, 16'h8001};
        apply_stimulus(4'd7, 1'b1);
        check("half_ftz_sign", 32'(h_sign[0]), 32'd1);
        check("half_ftz_expmant", 32'({h_exp[0], h_mant[0]}), 32'd0);
        check("half_ftz_class", 32'(h_class[0]), 32'(10'd1 << 2));
        check("half_ftz_flags", 32'({h_zero[0], h_den[0], h_flushed[0]}), 32'b101);
        check("half_snan_flags", 32'({h_inf[1], h_nan[1], h_snan[1]}), 32'b011);
        check("half_snan_class", 32'(h_class[1]), 32'(10'd1 << 8));
        check("half_snan_exp", 32'(h_exp[1]), 32'd31);
        check("half_snan_mant", 32'(h_mant[1]), 32'h500);
        check("half_ready", 32'(h_in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
